// File: rtl/layer_out_serializer.sv
// Serializes one layer's parallel neuron outputs into a word-per-clock stream.
// Neuron 0 is emitted first. out_last flags the final word of each frame.
module layer_out_serializer #(
  parameter int numNeurons = 30,
  parameter int dataWidth  = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [numNeurons*dataWidth-1:0]  in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [dataWidth-1:0]             out_data,
  output logic                             out_valid,
  output logic                             out_last,
  output logic                             drop_err
);

  localparam int IdxWidth   = (numNeurons > 1) ? $clog2(numNeurons) : 1;
  localparam int ShiftWords = (numNeurons > 1) ? numNeurons - 1 : 1;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(numNeurons - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                          state, state_next;
  logic [IdxWidth-1:0]             idx;
  logic [IdxWidth-1:0]             idx_inc;
  logic [ShiftWords*dataWidth-1:0] shift_reg;
  logic [ShiftWords*dataWidth-1:0] load_words;
  logic                            at_last;
  logic                            accept;

  // Words 1..N-1 of the incoming frame; a single-neuron layer has nothing to queue.
  generate
    if (numNeurons > 1) begin : g_multi
      assign load_words = in_data[numNeurons*dataWidth-1:dataWidth];
    end else begin : g_single
      assign load_words = '0;
    end
  endgenerate

  always_comb begin
    at_last    = (state == SHIFT) && (idx == LastIdx);
    in_ready   = (state == IDLE) || at_last;
    accept     = in_valid && in_ready;
    idx_inc    = idx + IdxWidth'(1);
    state_next = state;
    if (accept) begin
      state_next = SHIFT;
    end else if (at_last) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A new frame may load on the final-word cycle, giving back-to-back frames with no bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx       <= '0;
      shift_reg <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      if (in_valid && !in_ready) begin
        drop_err <= 1'b1;
      end
      if (accept) begin
        out_data  <= in_data[dataWidth-1:0];
        shift_reg <= load_words;
        idx       <= '0;
        out_valid <= 1'b1;
        out_last  <= (numNeurons == 1);
      end else if ((state == SHIFT) && !at_last) begin
        out_data  <= shift_reg[dataWidth-1:0];
        shift_reg <= shift_reg >> dataWidth;
        idx       <= idx_inc;
        out_last  <= (idx_inc == LastIdx);
      end else if (at_last) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_layer_out_serializer.sv
// Directed bench for layer_out_serializer: a 4-neuron instance for framing, drop and reset,
// plus a 1-neuron instance for the continuous single-word case.
module tb_layer_out_serializer;

  logic        clk;
  logic        reset;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        drop_err;

  logic [15:0] in_data1;
  logic        in_valid1;
  logic        in_ready1;
  logic [15:0] out_data1;
  logic        out_valid1;
  logic        out_last1;
  logic        drop_err1;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] FrameA = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
  localparam logic [63:0] FrameB = {16'hFFFC, 16'h8000, 16'h7FFF, 16'h0010};
  localparam logic [63:0] FrameX = {16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA};

  layer_out_serializer #(.numNeurons(4), .dataWidth(16)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .drop_err(drop_err)
  );

  layer_out_serializer #(.numNeurons(1), .dataWidth(16)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1),
    .out_last(out_last1), .drop_err(drop_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [63:0] data, input logic valid);
    in_data  = data;
    in_valid = valid;
  endtask

  task automatic expectWord(input string tag, input logic [15:0] data, input logic last);
    checkOutput({tag, " valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, " data"}, 32'(out_data), 32'(data));
    checkOutput({tag, " last"}, 32'(out_last), 32'(last));
  endtask

  task automatic doReset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    reset     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_data1  = '0;
    in_valid1 = 1'b0;

    // Reset state
    doReset();
    checkOutput("rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst out_last", 32'(out_last), 32'd0);
    checkOutput("rst in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst drop_err", 32'(drop_err), 32'd0);
    checkOutput("rst out_data", 32'(out_data), 32'd0);
    tick();
    tick();
    checkOutput("idle no output", 32'(out_valid), 32'd0);
    checkOutput("rst1 in_ready", 32'(in_ready1), 32'd1);
    checkOutput("rst1 out_valid", 32'(out_valid1), 32'd0);

    // Single frame
    applyStimulus(FrameA, 1'b1);
    tick();
    applyStimulus(FrameA, 1'b0);
    expectWord("t2 w0", 16'h0001, 1'b0);
    checkOutput("t2 busy in_ready", 32'(in_ready), 32'd0);
    tick(); expectWord("t2 w1", 16'h0002, 1'b0);
    tick(); expectWord("t2 w2", 16'h0003, 1'b0);
    tick(); expectWord("t2 w3", 16'h0004, 1'b1);
    checkOutput("t2 last in_ready", 32'(in_ready), 32'd1);
    tick();
    checkOutput("t2 end valid", 32'(out_valid), 32'd0);
    checkOutput("t2 end last", 32'(out_last), 32'd0);
    checkOutput("t2 hold data", 32'(out_data), 32'h0004);

    // Back-to-back frames
    applyStimulus(FrameA, 1'b1);
    tick();
    applyStimulus(FrameA, 1'b0);
    expectWord("t3 a0", 16'h0001, 1'b0);
    tick(); expectWord("t3 a1", 16'h0002, 1'b0);
    tick(); expectWord("t3 a2", 16'h0003, 1'b0);
    tick(); expectWord("t3 a3", 16'h0004, 1'b1);
    checkOutput("t3 in_ready", 32'(in_ready), 32'd1);
    applyStimulus(FrameB, 1'b1);
    tick();
    applyStimulus(FrameB, 1'b0);
    expectWord("t3 b0", 16'h0010, 1'b0);
    tick(); expectWord("t3 b1", 16'h7FFF, 1'b0);
    tick(); expectWord("t3 b2", 16'h8000, 1'b0);
    tick(); expectWord("t3 b3", 16'hFFFC, 1'b1);
    tick();
    checkOutput("t3 end valid", 32'(out_valid), 32'd0);
    checkOutput("t3 drop_err", 32'(drop_err), 32'd0);

    // Dropped frame mid-stream
    applyStimulus(FrameA, 1'b1);
    tick();
    applyStimulus(FrameA, 1'b0);
    expectWord("t4 w0", 16'h0001, 1'b0);
    tick(); expectWord("t4 w1", 16'h0002, 1'b0);
    checkOutput("t4 in_ready", 32'(in_ready), 32'd0);
    applyStimulus(FrameX, 1'b1);
    tick();
    applyStimulus(FrameX, 1'b0);
    expectWord("t4 w2", 16'h0003, 1'b0);
    checkOutput("t4 drop_err set", 32'(drop_err), 32'd1);
    tick(); expectWord("t4 w3", 16'h0004, 1'b1);
    tick();
    checkOutput("t4 end valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("t4 drop_err sticky", 32'(drop_err), 32'd1);
    checkOutput("t4 idle valid", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-frame
    doReset();
    checkOutput("t5 drop_err cleared", 32'(drop_err), 32'd0);
    applyStimulus(FrameA, 1'b1);
    tick();
    applyStimulus(FrameA, 1'b0);
    tick();
    tick();
    expectWord("t5 w2", 16'h0003, 1'b0);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("t5 async valid", 32'(out_valid), 32'd0);
    checkOutput("t5 async data", 32'(out_data), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    checkOutput("t5 post-rst valid", 32'(out_valid), 32'd0);
    applyStimulus(FrameB, 1'b1);
    tick();
    applyStimulus(FrameB, 1'b0);
    expectWord("t5 b0", 16'h0010, 1'b0);
    tick(); expectWord("t5 b1", 16'h7FFF, 1'b0);
    tick(); expectWord("t5 b2", 16'h8000, 1'b0);
    tick(); expectWord("t5 b3", 16'hFFFC, 1'b1);
    tick();

    // Single-neuron instance streaming every cycle
    for (int k = 0; k < 6; k++) begin
      checkOutput("t6 in_ready", 32'(in_ready1), 32'd1);
      in_data1  = 16'(16'h0100 + k);
      in_valid1 = 1'b1;
      tick();
      checkOutput("t6 valid", 32'(out_valid1), 32'd1);
      checkOutput("t6 last", 32'(out_last1), 32'd1);
      checkOutput("t6 data", 32'(out_data1), 32'(16'h0100 + k));
    end
    in_valid1 = 1'b0;
    checkOutput("t6 drop_err", 32'(drop_err1), 32'd0);
    tick();
    checkOutput("t6 end valid", 32'(out_valid1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
